// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler.
//   NREGS   : number of registers cleared by the post-reset sweep
//   AW_DEF  : default register address width
//   DW_DEF  : default register data width
//   state_t : scheduler state (INIT = clear sweep, RUN = arbitration)
//   next_ptr: round-robin pointer advance, (g + 1) mod n
package rf_sched_pkg;

   localparam int NREGS  = 32;
   localparam int AW_DEF = 5;
   localparam int DW_DEF = 32;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic int next_ptr(input int g, input int n);
      return (g + 1) % n;
   endfunction

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in  NREQ  request vector
//   ptr     in  PW    highest-priority index for this cycle
//   en      in  1     0 forces an all-zero grant
//   gnt     out NREQ  one-hot grant
//   gnt_idx out PW    index of the granted requester (0 when none)
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_idx
);

   // Walk the requesters starting at ptr, wrapping at NREQ; first hit wins.
   always_comb begin
      logic found;
      int   idx;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (en && !found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for a 32-entry register file that commits on the
// falling clock edge. After reset it clears every register, then shares
// the single write port between NREQ requesters in round-robin order.
// Ports:
//   clk        in  1       rising-edge clock
//   rst        in  1       synchronous reset, active low
//   hold       in  1       stall: no grants, sweep paused
//   req_valid  in  NREQ    requester i has a write pending
//   req_addr   in  NREQ*AW requester i destination, slice [i*AW +: AW]
//   req_data   in  NREQ*DW requester i data, slice [i*DW +: DW]
//   req_ready  out NREQ    one-hot combinational grant
//   rf_we      out 1       register-file write enable (registered)
//   rf_waddr   out AW      register-file write address (registered)
//   rf_wdata   out DW      register-file write data (registered)
//   init_done  out 1       clear sweep finished (registered)
//   wr_count   out 16      committed requester writes, wrapping
module regfile_wr_sched
   import rf_sched_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              rf_we,
   output logic [AW-1:0]     rf_waddr,
   output logic [DW-1:0]     rf_wdata,
   output logic              init_done,
   output logic [15:0]       wr_count
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state;
   logic [AW-1:0]   sweep_addr;
   logic [PW-1:0]   rr_ptr;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            arb_en;
   logic            grant_any;

   logic [AW-1:0]   addr_arr [NREQ];
   logic [DW-1:0]   data_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*AW +: AW];
         assign data_arr[gi] = req_data[gi*DW +: DW];
      end
   endgenerate

   // Reset is folded in so req_ready is low combinationally while rst=0.
   assign arb_en = rst && (state == RUN) && !hold;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   // The arbiter only grants valid requesters, so any grant is a transfer.
   assign grant_any = |gnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         wr_count   <= '0;
         rr_ptr     <= '0;
         sweep_addr <= '0;
         if (INIT_CLEAR != 0) begin
            state     <= INIT;
            init_done <= 1'b0;
         end else begin
            state     <= RUN;
            init_done <= 1'b1;
         end
      end else begin
         case (state)
            INIT: begin
               if (hold) begin
                  rf_we <= 1'b0;
               end else begin
                  rf_we      <= 1'b1;
                  rf_waddr   <= sweep_addr;
                  rf_wdata   <= '0;
                  sweep_addr <= sweep_addr + AW'(1);
                  // init_done rises together with the last sweep write.
                  if (sweep_addr == AW'(NREGS - 1)) begin
                     state     <= RUN;
                     init_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (grant_any) begin
                  rf_waddr <= addr_arr[gnt_idx];
                  rf_wdata <= data_arr[gnt_idx];
                  // Register 0 is hard-wired: consume the request, skip the write.
                  rf_we    <= (addr_arr[gnt_idx] != '0);
                  rr_ptr   <= PW'(next_ptr(int'(gnt_idx), NREQ));
                  wr_count <= wr_count + 16'd1;
               end else begin
                  rf_we <= 1'b0;
               end
            end
            default: begin
               rf_we <= 1'b0;
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          hold;
   logic [N-1:0]  req_valid;
   logic [N*5-1:0]  req_addr;
   logic [N*32-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;
   logic          init_done;
   logic [15:0]   wr_count;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int          m_ptr;
   logic [15:0] m_count;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   logic [4:0]  a_arr [N];
   logic [31:0] d_arr [N];

   regfile_wr_sched #(
      .NREQ       (N),
      .AW         (5),
      .DW         (32),
      .INIT_CLEAR (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .init_done (init_done),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pack();
      req_addr = {a_arr[2], a_arr[1], a_arr[0]};
      req_data = {d_arr[2], d_arr[1], d_arr[0]};
   endtask

   // Round-robin rule: first valid requester at or after ptr, wrapping.
   function automatic int model_pick(input logic [N-1:0] v, input int ptr, input logic h);
      if (h) return -1;
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b0; hold = 1'b0; req_valid = '1;
      a_arr[0] = 5'd1; a_arr[1] = 5'd2; a_arr[2] = 5'd3;
      d_arr[0] = 32'h1; d_arr[1] = 32'h2; d_arr[2] = 32'h3;
      pack();
      tick(); tick();
      #2;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0h want 0", rf_we); end
      total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr: got %0h want 0", rf_waddr); end
      total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", rf_wdata); end
      total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", wr_count); end
      total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done: got %0h want 0", init_done); end
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
      $display("reset: outputs checked");
   endtask

   // Call with rst=0 asserted; releases it and checks the full sweep.
   task automatic test_sweep();
      rst = 1'b1; hold = 1'b0; req_valid = '1;
      for (int i = 0; i < 32; i++) begin
         #2;
         total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL sweep_ready[%0d]: got %b want 000", i, req_ready); end
         tick();
         total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL sweep_we[%0d]: got %0h want 1", i, rf_we); end
         total++; if (rf_waddr !== 5'(i)) begin bad++; $display("FAIL sweep_waddr[%0d]: got %0d want %0d", i, rf_waddr, i); end
         total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL sweep_wdata[%0d]: got %0h want 0", i, rf_wdata); end
         total++; if (init_done !== (i == 31)) begin bad++; $display("FAIL sweep_init_done[%0d]: got %0h want %0h", i, init_done, (i == 31)); end
         $display("sweep: write addr %0d", rf_waddr);
      end
      req_valid = '0;
      m_ptr = 0; m_count = 16'd0;
   endtask

   task automatic test_round_robin();
      int exp_g [4] = '{0, 1, 2, 0};
      logic [4:0]  ea [3] = '{5'd1, 5'd2, 5'd3};
      logic [31:0] ed [3] = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF};
      for (int i = 0; i < 3; i++) begin a_arr[i] = ea[i]; d_arr[i] = ed[i]; end
      pack();
      req_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #2;
         total++; if (req_ready !== 3'(1 << exp_g[k])) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 3'(1 << exp_g[k])); end
         tick();
         total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL rr_we[%0d]: got %0h want 1", k, rf_we); end
         total++; if (rf_waddr !== ea[exp_g[k]]) begin bad++; $display("FAIL rr_waddr[%0d]: got %0d want %0d", k, rf_waddr, ea[exp_g[k]]); end
         total++; if (rf_wdata !== ed[exp_g[k]]) begin bad++; $display("FAIL rr_wdata[%0d]: got %0h want %0h", k, rf_wdata, ed[exp_g[k]]); end
         $display("rr: grant req%0d addr %0d data %h", exp_g[k], rf_waddr, rf_wdata);
      end
      total++; if (wr_count !== 16'd4) begin bad++; $display("FAIL rr_count: got %0d want 4", wr_count); end
      req_valid = '0;
      #2;
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rr_idle_we: got %0h want 0", rf_we); end
      total++; if (rf_waddr !== 5'd1) begin bad++; $display("FAIL rr_idle_waddr: got %0d want 1", rf_waddr); end
   endtask

   task automatic test_reg0();
      // Pointer is now 1 after grants 0,1,2,0.
      a_arr[1] = 5'd0; d_arr[1] = 32'hFFFFFFFF; pack();
      req_valid = 3'b010;
      #2;
      total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL reg0_ready: got %b want 010", req_ready); end
      tick();
      req_valid = 3'b000;
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reg0_we: got %0h want 0", rf_we); end
      total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reg0_waddr: got %0d want 0", rf_waddr); end
      total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL reg0_count: got %0d want 5", wr_count); end
      $display("reg0: req1 consumed, count %0d", wr_count);
      // Pointer must now be 2: with everyone valid req2 wins.
      a_arr[1] = 5'd2; d_arr[1] = 32'h89ABCDEF; pack();
      req_valid = 3'b111;
      #2;
      total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL reg0_ptr: got %b want 100", req_ready); end
      tick();
      total++; if (rf_waddr !== 5'd3 || rf_we !== 1'b1) begin bad++; $display("FAIL reg0_next_waddr: got %0d/%0h want 3/1", rf_waddr, rf_we); end
      $display("reg0: next grant req2 addr %0d", rf_waddr);
   endtask

   task automatic test_hold();
      hold = 1'b1; req_valid = 3'b111;
      for (int c = 0; c < 5; c++) begin
         #2;
         total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready[%0d]: got %b want 000", c, req_ready); end
         tick();
         total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL hold_we[%0d]: got %0h want 0", c, rf_we); end
         total++; if (wr_count !== 16'd6) begin bad++; $display("FAIL hold_count[%0d]: got %0d want 6", c, wr_count); end
      end
      hold = 1'b0;
      #2;
      total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL hold_resume_ready: got %b want 001", req_ready); end
      tick();
      req_valid = '0;
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || wr_count !== 16'd7) begin
         bad++; $display("FAIL hold_resume: got we=%0h addr=%0d cnt=%0d want 1/1/7", rf_we, rf_waddr, wr_count); end
      $display("hold: resumed with req0, count %0d", wr_count);
      m_ptr = 1; m_count = 16'd7; m_waddr = 5'd1; m_wdata = 32'h01234567;
   endtask

   task automatic test_random();
      logic [N-1:0] pend = '0;
      int g;
      logic exp_we;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i]  = 1'b1;
               a_arr[i] = 5'($urandom_range(31, 0));
               d_arr[i] = $urandom;
            end
         end
         pack();
         req_valid = pend;
         hold = ($urandom_range(4, 0) == 0);
         #2;
         g = model_pick(pend, m_ptr, hold);
         total++; if (req_ready !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin
            bad++; $display("FAIL rand_ready[%0d]: got %b want grant %0d", c, req_ready, g); end
         tick();
         if (g >= 0) begin
            m_waddr = a_arr[g]; m_wdata = d_arr[g];
            m_ptr = (g + 1) % N; m_count = m_count + 16'd1;
            pend[g] = 1'b0;
            exp_we = (a_arr[g] != 5'd0);
         end else begin
            exp_we = 1'b0;
         end
         total++; if (rf_we !== exp_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata || wr_count !== m_count) begin
            bad++; $display("FAIL rand_out[%0d]: got we=%0h a=%0d d=%h n=%0d want we=%0h a=%0d d=%h n=%0d",
                            c, rf_we, rf_waddr, rf_wdata, wr_count, exp_we, m_waddr, m_wdata, m_count); end
         $display("rand: cycle %0d grant %0d we %0h addr %0d", c, g, rf_we, rf_waddr);
      end
      hold = 1'b0; req_valid = '0;
   endtask

   task automatic test_count_wrap();
      int n;
      a_arr[0] = 5'd5; d_arr[0] = 32'hA5A5A5A5; pack();
      req_valid = 3'b001; hold = 1'b0;
      n = 32'hFFFF - int'(m_count);
      repeat (n) tick();
      #2;
      total++; if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre: got %h want ffff", wr_count); end
      tick();
      total++; if (wr_count !== 16'h0000) begin bad++; $display("FAIL wrap: got %h want 0000", wr_count); end
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin bad++; $display("FAIL wrap_write: got %0h/%0d want 1/5", rf_we, rf_waddr); end
      $display("wrap: count %h after %0d grants", wr_count, n + 1);
   endtask

   task automatic test_reset_mid_sweep();
      // Reset in RUN with a write presented: it must be dropped.
      rst = 1'b0; req_valid = 3'b111;
      #2;
      total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rstrun_ready: got %b want 000", req_ready); end
      tick();
      total++; if (rf_we !== 1'b0 || wr_count !== 16'd0) begin bad++; $display("FAIL rstrun: got we=%0h n=%0d want 0/0", rf_we, wr_count); end
      tick();
      rst = 1'b1;
      repeat (17) tick();
      total++; if (rf_waddr !== 5'd16 || rf_we !== 1'b1) begin bad++; $display("FAIL midsweep_pre: got %0d/%0h want 16/1", rf_waddr, rf_we); end
      rst = 1'b0;
      tick();
      total++; if (rf_we !== 1'b0 || init_done !== 1'b0) begin bad++; $display("FAIL midsweep_rst: got we=%0h done=%0h want 0/0", rf_we, init_done); end
      $display("midsweep: reset at sweep_addr 17, restarting");
      test_sweep();
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_round_robin();
      test_reg0();
      test_hold();
      test_random();
      test_count_wrap();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
